// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared memory-bus widths, arbiter state encoding and port ids
package cpu_mem_pkg;
  localparam int AW_DEF = 7;
  localparam int DW_DEF = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, req[0]=instruction, req[1]=data, gnt 0=I 1=D
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction and data ports, fixed 3-cycle access
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic          M_EN,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA
);
  logic [1:0]    r_state;
  logic          r_gnt;
  logic          r_last;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_irdata;
  logic [DW-1:0] r_drdata;
  logic          w_gnt;
  logic          w_issue;
  logic          w_resp;
  rr_arb2 u_rr (
    .req ({D_REQ, I_REQ}),
    .last(r_last),
    .gnt (w_gnt)
  );
  // reset kills the access in the same cycle: no RAM strobe, no ACK
  assign w_issue = (r_state == S_ISSUE) && !RST;
  assign w_resp  = (r_state == S_RESP) && !RST;
  assign M_EN    = w_issue;
  assign M_WE    = w_issue && r_we;
  assign M_ADDR  = r_addr;
  assign M_WDATA = r_wdata;
  assign I_ACK   = w_resp && (r_gnt == P_I);
  assign D_ACK   = w_resp && (r_gnt == P_D);
  assign I_RDATA = I_ACK ? M_RDATA : r_irdata;
  assign D_RDATA = D_ACK ? (r_we ? '0 : M_RDATA) : r_drdata;
  // IDLE -> ISSUE -> RESP -> IDLE; latch winner and its command, keep read data between ACKs
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_last   <= P_D;
      r_gnt    <= P_I;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      r_irdata <= I_RDATA;
      r_drdata <= D_RDATA;
      if (r_state == S_IDLE && (I_REQ || D_REQ)) begin
        r_state <= S_ISSUE;
        r_gnt   <= w_gnt;
        r_we    <= w_gnt && D_WE;
        r_addr  <= w_gnt ? D_ADDR : I_ADDR;
        r_wdata <= w_gnt ? D_WDATA : '0;
      end else if (r_state == S_ISSUE) begin
        r_state <= S_RESP;
      end else if (r_state == S_RESP) begin
        r_state <= S_IDLE;
        r_last  <= r_gnt;
      end else if (r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue-based ACK scoreboard for mem_arbiter
module tb_mem_arbiter;
  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        I_REQ = 1'b0;
  logic [6:0]  I_ADDR = '0;
  logic        I_ACK;
  logic [15:0] I_RDATA;
  logic        D_REQ = 1'b0;
  logic        D_WE = 1'b0;
  logic [6:0]  D_ADDR = '0;
  logic [15:0] D_WDATA = '0;
  logic        D_ACK;
  logic [15:0] D_RDATA;
  logic        M_EN;
  logic        M_WE;
  logic [6:0]  M_ADDR;
  logic [15:0] M_WDATA;
  logic [15:0] M_RDATA = '0;
  logic [15:0] mem [128];
  logic [127:0] wr = '0;
  int errs = 0;
  int checks = 0;
  int nwe = 0;
  typedef struct packed {logic port; logic [15:0] data;} exp_t;
  exp_t q[$];

  mem_arbiter dut (
    .CK(CK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .M_EN(M_EN), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA)
  );

  always #5 CK = ~CK;

  function automatic logic [15:0] init_val(input logic [6:0] a);
    return a == 7'd3 ? 16'hC301 : a == 7'd4 ? 16'h4444 : a == 7'd5 ? 16'h5555 :
           (a >= 7'd10 && a <= 7'd12) ? 16'h1000 + 16'(a - 7'd10) :
           (a >= 7'd20 && a <= 7'd22) ? 16'hD000 + 16'(a - 7'd20) : 16'h0000;
  endfunction

  always @(posedge CK)
    if (M_EN) begin
      if (M_WE) begin
        mem[M_ADDR] <= M_WDATA;
        wr[M_ADDR]  <= 1'b1;
      end else begin
        M_RDATA <= wr[M_ADDR] ? mem[M_ADDR] : init_val(M_ADDR);
      end
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    q.push_back(e);
  endtask

  always @(negedge CK) begin
    if (M_WE) nwe++;
    if (I_ACK || D_ACK) begin
      check("ack_exclusive", {31'd0, I_ACK & D_ACK}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL ack_unexpected: got ack I=%0b D=%0b expected none", I_ACK, D_ACK);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_port", {31'd0, D_ACK}, {31'd0, e.port});
        check("ack_data", {16'd0, D_ACK ? D_RDATA : I_RDATA}, {16'd0, e.data});
      end
    end
  end

  task automatic acc_i(input logic [6:0] a, input int elat);
    int n = 0;
    I_ADDR = a;
    I_REQ  = 1'b1;
    do begin
      @(negedge CK);
      n++;
    end while (!I_ACK && n < 30);
    check("i_latency", n, elat);
    @(posedge CK);
    #1 I_REQ = 1'b0;
  endtask

  task automatic acc_d(input logic we, input logic [6:0] a, input logic [15:0] wd, input int elat);
    int n = 0;
    D_WE    = we;
    D_ADDR  = a;
    D_WDATA = wd;
    D_REQ   = 1'b1;
    do begin
      @(negedge CK);
      n++;
    end while (!D_ACK && n < 30);
    check("d_latency", n, elat);
    @(posedge CK);
    #1 D_REQ = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i_ack"}, {31'd0, I_ACK}, 32'd0);
    check({tag, "_d_ack"}, {31'd0, D_ACK}, 32'd0);
    check({tag, "_m_en"}, {31'd0, M_EN}, 32'd0);
    check({tag, "_m_we"}, {31'd0, M_WE}, 32'd0);
    check({tag, "_m_addr"}, {25'd0, M_ADDR}, 32'd0);
    check({tag, "_m_wdata"}, {16'd0, M_WDATA}, 32'd0);
    check({tag, "_i_rdata"}, {16'd0, I_RDATA}, 32'd0);
    check({tag, "_d_rdata"}, {16'd0, D_RDATA}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CK);
    @(negedge CK);
    check_reset_outputs("reset");
    @(posedge CK);
    #1 RST = 1'b0;
    @(posedge CK);
    #1 I_ADDR = 7'd3;
    I_REQ = 1'b1;
    push(1'b0, 16'hC301);
    @(negedge CK);
    check("idle_m_en", {31'd0, M_EN}, 32'd0);
    @(negedge CK);
    check("issue_m_en", {31'd0, M_EN}, 32'd1);
    check("issue_m_addr", {25'd0, M_ADDR}, 32'd3);
    check("issue_m_we", {31'd0, M_WE}, 32'd0);
    @(negedge CK);
    check("resp_i_ack", {31'd0, I_ACK}, 32'd1);
    check("resp_d_ack", {31'd0, D_ACK}, 32'd0);
    @(posedge CK);
    #1 I_REQ = 1'b0;
    @(negedge CK);
    check("after_i_ack", {31'd0, I_ACK}, 32'd0);
    check("hold_i_rdata", {16'd0, I_RDATA}, {16'd0, 16'hC301});
    @(posedge CK);
    #1;
    push(1'b1, 16'h0000);
    acc_d(1'b1, 7'd0, 16'h0037, 3);
    push(1'b1, 16'h0037);
    acc_d(1'b0, 7'd0, 16'h0000, 3);
    check("m_we_cycles", nwe, 1);
    for (int r = 0; r < 2; r++) begin
      push(1'b0, 16'h4444);
      push(1'b1, 16'h5555);
      fork
        acc_i(7'd4, 3);
        acc_d(1'b0, 7'd5, 16'h0000, 6);
      join
    end
    push(1'b0, 16'hC301);
    acc_i(7'd3, 3);
    push(1'b1, 16'h5555);
    push(1'b0, 16'h4444);
    fork
      acc_i(7'd4, 6);
      acc_d(1'b0, 7'd5, 16'h0000, 3);
    join
    push(1'b1, 16'hD000);
    push(1'b0, 16'h1000);
    push(1'b1, 16'hD001);
    push(1'b0, 16'h1001);
    push(1'b1, 16'hD002);
    push(1'b0, 16'h1002);
    fork
      begin
        acc_d(1'b0, 7'd20, 16'h0000, 3);
        acc_d(1'b0, 7'd21, 16'h0000, 6);
        acc_d(1'b0, 7'd22, 16'h0000, 6);
      end
      begin
        acc_i(7'd10, 6);
        acc_i(7'd11, 6);
        acc_i(7'd12, 6);
      end
    join
    I_ADDR = 7'd3;
    I_REQ  = 1'b1;
    @(posedge CK);
    @(posedge CK);
    #1 RST = 1'b1;
    I_REQ = 1'b0;
    @(negedge CK);
    check("abort_i_ack", {31'd0, I_ACK}, 32'd0);
    @(posedge CK);
    #1 RST = 1'b0;
    @(negedge CK);
    check_reset_outputs("abort");
    @(posedge CK);
    #1;
    push(1'b0, 16'h4444);
    push(1'b1, 16'h5555);
    fork
      acc_i(7'd4, 3);
      acc_d(1'b0, 7'd5, 16'h0000, 6);
    join
    push(1'b0, 16'hC301);
    I_ADDR = 7'd3;
    I_REQ  = 1'b1;
    @(posedge CK);
    #1 I_REQ = 1'b0;
    @(negedge CK);
    check("drop_issue_m_en", {31'd0, M_EN}, 32'd1);
    @(negedge CK);
    check("drop_resp_i_ack", {31'd0, I_ACK}, 32'd1);
    @(negedge CK);
    check("drop_idle_m_en0", {31'd0, M_EN}, 32'd0);
    @(negedge CK);
    check("drop_idle_m_en1", {31'd0, M_EN}, 32'd0);
    repeat (2) @(negedge CK);
    check("scoreboard_empty", q.size(), 0);
    check("m_we_total", nwe, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
